// File: rtl/bus_arbiter.sv
// Three-way round-robin bus arbiter: CPU, DMA RX, DMA TX with idle gap between owners.
// Define BUS_ARBITER_TIMEOUT_EN to bound ownership and mask a revoked requester.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int GAP_CYCLES     = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] Req,
    output logic [2:0] Grant,
    output logic       Busy,
    output logic [1:0] Owner,
    output logic       Timeout
);

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        GAP
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t     state, state_n;
    logic [2:0] grant_n;
    logic [1:0] last_owner, last_owner_n;
    logic [1:0] winner;
    logic [3:0] gap_cnt, gap_cnt_n;
    logic [2:0] eligible;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt, tcnt_n;
    logic [2:0]    mask, mask_n;
    logic          timeout_n;

    assign eligible = Req & ~mask;
`else
    assign eligible = Req;
    assign Timeout  = 1'b0;
`endif

    assign Busy = |Grant;

    always_comb begin
        Owner = 2'd0;
        unique case (1'b1)
            Grant[0]: Owner = 2'd0;
            Grant[1]: Owner = 2'd1;
            Grant[2]: Owner = 2'd2;
            default:  Owner = 2'd0;
        endcase
    end

    // Search begins just past the previous owner, so it ranks last.
    always_comb begin
        winner = 2'd0;
        case (last_owner)
            2'd0: winner = eligible[1] ? 2'd1 :
                           eligible[2] ? 2'd2 : 2'd0;
            2'd1: winner = eligible[2] ? 2'd2 :
                           eligible[0] ? 2'd0 : 2'd1;
            default: winner = eligible[0] ? 2'd0 :
                              eligible[1] ? 2'd1 : 2'd2;
        endcase
    end

    always_comb begin
        state_n      = state;
        grant_n      = Grant;
        last_owner_n = last_owner;
        gap_cnt_n    = gap_cnt;
`ifdef BUS_ARBITER_TIMEOUT_EN
        tcnt_n    = tcnt;
        mask_n    = mask & Req;
        timeout_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_n      = OWNED;
                    grant_n      = 3'b001 << winner;
                    last_owner_n = winner;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    tcnt_n = '0;
`endif
                end
            end
            OWNED: begin
                if (~|(Req & Grant)) begin
                    state_n   = GAP;
                    grant_n   = 3'b000;
                    gap_cnt_n = GAP_LOAD;
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (tcnt == T_LAST) begin
                    state_n   = GAP;
                    grant_n   = 3'b000;
                    gap_cnt_n = GAP_LOAD;
                    timeout_n = 1'b1;
                    mask_n    = mask_n | Grant;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
`endif
            end
            GAP: begin
                if (gap_cnt == 4'd0) state_n = IDLE;
                else gap_cnt_n = gap_cnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            Grant      <= 3'b000;
            last_owner <= 2'd2;
            gap_cnt    <= 4'd0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            tcnt    <= '0;
            mask    <= 3'b000;
            Timeout <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            Grant      <= grant_n;
            last_owner <= last_owner_n;
            gap_cnt    <= gap_cnt_n;
`ifdef BUS_ARBITER_TIMEOUT_EN
            tcnt    <= tcnt_n;
            mask    <= mask_n;
            Timeout <= timeout_n;
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random requests vs. a behavioural model.
// Build with or without BUS_ARBITER_TIMEOUT_EN; the bench adapts.
module tb_bus_arbiter;

    localparam int GAP = 1;
    localparam int TMO = 8;
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst;
    logic [2:0] Req;
    logic [2:0] Grant;
    logic       Busy;
    logic [1:0] Owner;
    logic       Timeout;

    int checks = 0;
    int errors = 0;

    // Reference state: who owns the bus, how long, and cycles still blocked.
    int       m_own;
    int       m_last;
    int       m_block;
    int       m_held;
    logic [2:0] m_mask;
    logic       m_to;

    bus_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Req    (Req),
        .Grant  (Grant),
        .Busy   (Busy),
        .Owner  (Owner),
        .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [6:0] obs,
                       input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_vec();
        logic [2:0] g;
        logic [1:0] o;
        g = 3'b000;
        o = 2'd0;
        if (m_own >= 0) begin
            g = 3'(1 << m_own);
            o = 2'(m_own);
        end
        return {g, (m_own >= 0), o, m_to};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {Grant, Busy, Owner, Timeout};
    endfunction

    task automatic model_reset();
        m_own   = -1;
        m_last  = 2;
        m_block = 0;
        m_held  = 0;
        m_mask  = 3'b000;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [2:0] r);
        logic [2:0] revoked;
        logic [2:0] elig;
        logic       to;
        int         idx;
        revoked = 3'b000;
        to      = 1'b0;
        elig    = r & ~m_mask;
        if (m_own >= 0) begin
            if (!r[m_own]) begin
                m_own   = -1;
                m_block = GAP;
            end else if (TO_EN && m_held == TMO) begin
                revoked = 3'(1 << m_own);
                m_own   = -1;
                m_block = GAP;
                to      = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_block > 0) begin
            m_block--;
        end else if (elig != 3'b000) begin
            for (int i = 1; i <= 3; i++) begin
                idx = (m_last + i) % 3;
                if (m_own < 0 && elig[idx]) m_own = idx;
            end
            m_last = m_own;
            m_held = 1;
        end
        m_mask = (m_mask & r) | (TO_EN ? revoked : 3'b000);
        m_to   = to;
    endtask

    task automatic step(input logic [2:0] r, input string tag);
        Req = r;
        @(posedge Clk);
        model_edge(r);
        @(negedge Clk);
        chk(tag, obs_vec(), exp_vec());
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        Req = 3'b000;
        #1;
        model_reset();
        chk("reset_now", obs_vec(), 7'b0);
        @(posedge Clk);
        @(negedge Clk);
        chk("reset_hold", obs_vec(), 7'b0);
        Rst = 1'b0;
    endtask

    initial begin
        logic [2:0] order [4];
        logic [2:0] r;
        int         n;
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
        Rst = 1'b1;
        Req = 3'b000;
        model_reset();
        @(negedge Clk);
        do_reset();

        // Single CPU transaction and the post-release gap
        step(3'b001, "029_grant");
        chk("029_c1", obs_vec(), 7'b001_1_00_0);
        for (int i = 0; i < 4; i++) step(3'b001, "029_hold");
        step(3'b000, "029_drop");
        chk("029_clear", {4'b0, Grant}, 7'b0);
        step(3'b001, "029_gap");
        chk("029_nogrant", {4'b0, Grant}, 7'b0);
        step(3'b001, "029_idle");
        chk("029_regrant", {4'b0, Grant}, 7'b001);

        // Round-robin rotation with all three requesting
        do_reset();
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (Grant == 3'b000 && n < 10) begin
                step(3'b111, "030_wait");
                n++;
            end
            chk("030_order", {4'b0, Grant}, {4'b0, order[k]});
            for (int i = 0; i < 3; i++) step(3'b111, "030_hold");
            step(3'b111 & ~order[k], "030_drop");
        end

        // No preemption of a holding owner
        do_reset();
        step(3'b010, "031_grant");
        chk("031_first", obs_vec(), 7'b010_1_01_0);
        for (int i = 0; i < 3; i++) begin
            step(3'b110, "031_hold");
            chk("031_stay", {4'b0, Grant}, 7'b010);
        end
        step(3'b100, "031_drop");
        step(3'b100, "031_gap");
        step(3'b100, "031_idle");
        chk("031_tx", obs_vec(), 7'b100_1_10_0);

        // Asynchronous reset mid-ownership
        #2;
        Rst = 1'b1;
        #1;
        model_reset();
        chk("032_async", obs_vec(), 7'b0);
        @(negedge Clk);
        Rst = 1'b0;
        step(3'b111, "032_after");
        chk("032_cpu", {4'b0, Grant}, 7'b001);

`ifdef BUS_ARBITER_TIMEOUT_EN
        // Forced revoke, masking and hand-off to the CPU
        do_reset();
        step(3'b010, "033_grant");
        for (int i = 1; i < TMO; i++) begin
            step(3'b011, "033_hold");
            chk("033_own", {4'b0, Grant}, 7'b010);
        end
        step(3'b011, "033_revoke");
        chk("033_pulse", obs_vec(), 7'b000_0_00_1);
        step(3'b011, "033_gap");
        chk("033_pulse_end", {6'b0, Timeout}, 7'b0);
        step(3'b011, "033_cpu");
        chk("033_cpu_grant", {4'b0, Grant}, 7'b001);
        for (int i = 0; i < 4; i++) step(3'b010, "033_masked");
        chk("033_still_masked", {4'b0, Grant}, 7'b0);
        step(3'b000, "033_unmask");
        step(3'b010, "033_rereq");
        chk("033_regrant", {4'b0, Grant}, 7'b010);
`else
        // Ownership is unbounded without the timeout feature
        do_reset();
        for (int i = 0; i < 1000; i++) step(3'b010, "034_hold");
        chk("034_owner", obs_vec(), 7'b010_1_01_0);
`endif

        // Random traffic against the model, with occasional resets
        do_reset();
        r = 3'b000;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(r, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: max consecutive owned cycles before forced revoke (used only with BUS_ARBITER_TIMEOUT_EN).
REQ-002 Parameter GAP_CYCLES, default 1: idle cycles inserted between release and next grant; legal range 1..15.
REQ-003 Clk  input  1  system clock; all state updates on rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 Req  input  3  bus requests; bit0 CPU, bit1 DMA RX, bit2 DMA TX; level, held high while bus wanted.
REQ-006 Grant  output  3  registered one-hot bus grant, same bit order as Req.
REQ-007 Busy  output  1  high while any Grant bit is high.
REQ-008 Owner  output  2  encoded index of granted requester; 0 when Busy low.
REQ-009 Timeout  output  1  one-cycle pulse on forced revoke; constant 0 when macro absent.

Function
REQ-010 FSM states: IDLE, OWNED, GAP; reset state IDLE.
REQ-011 IDLE: if any eligible Req bit is high at an edge, the next edge enters OWNED with Grant one-hot to the winner; grant latency exactly 1 cycle from Req sampled high.
REQ-012 IDLE with no eligible Req: remain IDLE, Grant = 0.
REQ-013 Arbitration round-robin: search starts at index (last_owner + 1) mod 3, first eligible high Req wins.
REQ-014 last_owner updates only on entry to OWNED; after reset last_owner = 2, so CPU (bit0) has first priority.
REQ-015 OWNED: Grant held stable while owner's Req is high; other requests never preempt.
REQ-016 OWNED, owner Req sampled low: next edge clears Grant and enters GAP.
REQ-017 GAP: Grant = 0 for exactly GAP_CYCLES cycles via down-counter, then IDLE; requests during GAP are evaluated on the IDLE cycle, adding one cycle before next grant.
REQ-018 Owner re-asserting Req in GAP is arbitrated normally; round-robin places it last.
REQ-019 Simultaneous Req rise on several bits in IDLE: single winner per REQ-013; Grant never has more than one bit set.
REQ-020 Req bit not in eligible set (see REQ-027) ignored.
REQ-021 Busy and Owner derived from registered Grant, no combinational path from Req.

Reset
REQ-022 Rst high: immediately Grant = 0, Busy = 0, Owner = 0, Timeout = 0, state IDLE, gap counter 0, last_owner = 2, timeout counter 0, mask 0.
REQ-023 Rst asserted mid-ownership revokes the grant without GAP; first grant after deassertion follows REQ-011 and REQ-014.
REQ-024 Rst deassertion synchronous-release; no grant on the first edge after release unless Req was high at that edge.

Configuration
REQ-025 Macro BUS_ARBITER_TIMEOUT_EN defined: counter increments each OWNED cycle, clears on OWNED entry.
REQ-026 Counter reaching TIMEOUT_CYCLES: next edge clears Grant, pulses Timeout one cycle, enters GAP, sets mask bit of the revoked requester.
REQ-027 Eligible set = Req & ~mask; mask bit clears when that Req is sampled low.
REQ-028 Macro undefined: no counter, no mask (all Req eligible), Timeout tied 0, ownership unbounded.

Verification
REQ-029 Req=001 at cycle 0 -> Grant=001, Owner=0, Busy=1 from cycle 1; Req=000 at cycle 5 -> Grant=000 at cycle 6, next grant possible no earlier than cycle 8 (GAP_CYCLES=1).
REQ-030 Req=111 held, each owner drops Req 4 cycles after grant then re-raises -> grant order 001,010,100,001.
REQ-031 Owner 1 holds Req=010 while Req bit2 rises -> Grant stays 010 until bit1 drops; then GAP, then Grant=100.
REQ-032 Rst pulsed 1 cycle while Grant=100 -> Grant=000 in same cycle; Req=111 after release -> Grant=001.
REQ-033 With BUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8, Req=010 held -> Grant=010 for 8 cycles, Timeout 1-cycle pulse, Grant=000, no re-grant to bit1 until Req bit1 low then high; Req bit0 high meanwhile -> Grant=001 after GAP.
REQ-034 Without macro, Req=010 held 1000 cycles -> Grant=010 throughout, Timeout never 1.
